// File: rtl/event_counter_pkg.sv
// Shared types and helpers for the event counter bank.
// Holds the counter mode constants and the per-channel action encoding.
package event_counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  typedef enum logic [1:0] {
    HOLD,
    CLEAR,
    WRITE,
    INC
  } cnt_action_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/event_counter_channel.sv
// One event counter channel: clear > write > increment > hold.
// Wraps or saturates at all-ones and keeps a sticky overflow flag.
module event_counter_channel
  import event_counter_pkg::*;
#(
  parameter int WIDTH    = 20,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  cnt_action_t      act;
  logic             at_max;

  assign at_max = &count_q;

  always_comb begin
    if (clear_i)    act = CLEAR;
    else if (wr_i)  act = WRITE;
    else if (inc_i) act = INC;
    else            act = HOLD;
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unique case (act)
      CLEAR: begin
        count_d = '0;
        ovf_d   = 1'b0;
      end
      WRITE: begin
        count_d = wr_data_i;
        ovf_d   = 1'b0;
      end
      INC: begin
        if (at_max) begin
          ovf_d = 1'b1;
          // saturating mode simply leaves the count parked at max
          if (SATURATE != CNT_SAT)
            count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters with a registered read port.
// EVENT_COUNTER_SNAPSHOT_EN adds an atomic shadow copy read by the port.
module event_counter_bank
  import event_counter_pkg::*;
#(
  parameter  int CHANNELS = 3,
  parameter  int WIDTH    = 20,
  parameter  int SATURATE = CNT_WRAP,
  localparam int SEL_W    = sel_width(CHANNELS)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [CHANNELS-1:0]       event_i,
  input  logic [CHANNELS-1:0]       enable_i,
  input  logic [CHANNELS-1:0]       clear_i,
  input  logic                      wr_en_i,
  input  logic [SEL_W-1:0]          wr_sel_i,
  input  logic [WIDTH-1:0]          wr_data_i,
  input  logic [SEL_W-1:0]          rd_sel_i,
  output logic [WIDTH-1:0]          rd_data_o,
  output logic                      rd_overflow_o,
  output logic [CHANNELS*WIDTH-1:0] count_flat_o,
  output logic [CHANNELS-1:0]       overflow_o,
  output logic                      any_overflow_o
`ifdef EVENT_COUNTER_SNAPSHOT_EN
  ,
  input  logic                      snap_i,
  output logic                      snap_valid_o
`endif
);

  logic [WIDTH-1:0]    cnt [CHANNELS];
  logic [CHANNELS-1:0] ovf;
  logic [WIDTH-1:0]    src_cnt [CHANNELS];
  logic [CHANNELS-1:0] src_ovf;
  logic [WIDTH-1:0]    rd_data_q, rd_data_d;
  logic                rd_ovf_q, rd_ovf_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr;
    // out-of-range wr_sel matches no channel, so the write is dropped
    assign wr = wr_en_i && (wr_sel_i == SEL_W'(i));

    event_counter_channel #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_ch (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .clear_i    (clear_i[i]),
      .wr_i       (wr),
      .wr_data_i  (wr_data_i),
      .inc_i      (event_i[i] && enable_i[i]),
      .count_o    (cnt[i]),
      .overflow_o (ovf[i])
    );

    assign count_flat_o[i*WIDTH +: WIDTH] = cnt[i];
  end

  assign overflow_o     = ovf;
  assign any_overflow_o = |ovf;

`ifdef EVENT_COUNTER_SNAPSHOT_EN
  logic [WIDTH-1:0]    snap_cnt_q [CHANNELS];
  logic [CHANNELS-1:0] snap_ovf_q;
  logic                snap_valid_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < CHANNELS; i++)
        snap_cnt_q[i] <= '0;
      snap_ovf_q   <= '0;
      snap_valid_q <= 1'b0;
    end else if (snap_i) begin
      snap_cnt_q   <= cnt;
      snap_ovf_q   <= ovf;
      snap_valid_q <= 1'b1;
    end
  end

  assign src_cnt      = snap_cnt_q;
  assign src_ovf      = snap_ovf_q;
  assign snap_valid_o = snap_valid_q;
`else
  assign src_cnt = cnt;
  assign src_ovf = ovf;
`endif

  always_comb begin
    rd_data_d = '0;
    rd_ovf_d  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (rd_sel_i == SEL_W'(i)) begin
        rd_data_d = src_cnt[i];
        rd_ovf_d  = src_ovf[i];
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_data_q <= '0;
      rd_ovf_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_ovf_q  <= rd_ovf_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_overflow_o = rd_ovf_q;

endmodule

// File: tb/tb_event_counter_bank.sv
// Directed bench: a wrapping and a saturating 3x4-bit bank on shared stimulus.
// Snapshot checks compile in with EVENT_COUNTER_SNAPSHOT_EN.
module tb_event_counter_bank;

  localparam int CH = 3;
  localparam int W  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] ev, en, clr;
  logic          wr_en;
  logic [SW-1:0] wr_sel, rd_sel;
  logic [W-1:0]  wr_data;

  logic [W-1:0]    rd_a, rd_b;
  logic            rdo_a, rdo_b;
  logic [CH*W-1:0] flat_a, flat_b;
  logic [CH-1:0]   ovf_a, ovf_b;
  logic            any_a, any_b;
`ifdef EVENT_COUNTER_SNAPSHOT_EN
  logic snap, sv_a, sv_b;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  event_counter_bank #(.CHANNELS(CH), .WIDTH(W), .SATURATE(0)) u_wrap (
    .clock_i        (clk),
    .reset_i        (rst),
    .event_i        (ev),
    .enable_i       (en),
    .clear_i        (clr),
    .wr_en_i        (wr_en),
    .wr_sel_i       (wr_sel),
    .wr_data_i      (wr_data),
    .rd_sel_i       (rd_sel),
    .rd_data_o      (rd_a),
    .rd_overflow_o  (rdo_a),
    .count_flat_o   (flat_a),
    .overflow_o     (ovf_a),
    .any_overflow_o (any_a)
`ifdef EVENT_COUNTER_SNAPSHOT_EN
    ,
    .snap_i         (snap),
    .snap_valid_o   (sv_a)
`endif
  );

  event_counter_bank #(.CHANNELS(CH), .WIDTH(W), .SATURATE(1)) u_sat (
    .clock_i        (clk),
    .reset_i        (rst),
    .event_i        (ev),
    .enable_i       (en),
    .clear_i        (clr),
    .wr_en_i        (wr_en),
    .wr_sel_i       (wr_sel),
    .wr_data_i      (wr_data),
    .rd_sel_i       (rd_sel),
    .rd_data_o      (rd_b),
    .rd_overflow_o  (rdo_b),
    .count_flat_o   (flat_b),
    .overflow_o     (ovf_b),
    .any_overflow_o (any_b)
`ifdef EVENT_COUNTER_SNAPSHOT_EN
    ,
    .snap_i         (snap),
    .snap_valid_o   (sv_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ca(input int i);
    return 32'(flat_a[i*W +: W]);
  endfunction

  function automatic logic [31:0] cb(input int i);
    return 32'(flat_b[i*W +: W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int sel, input int data);
    wr_en   = 1'b1;
    wr_sel  = SW'(sel);
    wr_data = W'(data);
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ev = '0; en = '1; clr = '0;
    wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel = '0;
`ifdef EVENT_COUNTER_SNAPSHOT_EN
    snap = 1'b0;
`endif
    tick(); tick();
    chk("rst_flat", 32'(flat_a), 0);
    chk("rst_any", 32'(any_a), 0);
    chk("rst_rd", 32'(rd_a), 0);
    rst = 1'b0;

    // reset aborts a running count
    wr(0, 5);
    chk("pre_c0", ca(0), 5);
    ev = 3'b001;
    tick();
    chk("run_c0", ca(0), 6);
`ifndef EVENT_COUNTER_SNAPSHOT_EN
    chk("run_rd", 32'(rd_a), 5);
`endif
    #3 rst = 1'b1;
    #1;
    chk("arst_flat", 32'(flat_a), 0);
    chk("arst_rd", 32'(rd_a), 0);
    chk("arst_ovf", 32'(ovf_a), 0);
    ev = '0;
    tick();
    rst = 1'b0;

    // wrap vs saturate on CH1
    wr(1, 14);
    chk("pl_c1", cb(1), 14);
    ev = 3'b010;
    tick();
    chk("w1_a", ca(1), 15);
    chk("w1_b", cb(1), 15);
    chk("w1_ovf", 32'(ovf_a), 0);
    tick();
    chk("w2_a", ca(1), 0);
    chk("w2_b", cb(1), 15);
    chk("w2_ovfa", 32'(ovf_a), 32'b010);
    chk("w2_ovfb", 32'(ovf_b), 32'b010);
    tick();
    chk("w3_a", ca(1), 1);
    chk("w3_b", cb(1), 15);
    chk("w3_ovfa", 32'(ovf_a), 32'b010);
    chk("w3_anyb", 32'(any_b), 1);
    ev = 3'b010; en = 3'b101;
    tick();
    chk("gate_a", ca(1), 1);
    ev = '0; en = '1;

    // priority and per-channel independence
    wr(2, 15);
    ev = 3'b100;
    tick();
    chk("p0_c2a", ca(2), 0);
    chk("p0_ovfa", 32'(ovf_a), 32'b110);
    clr = 3'b100; ev = 3'b101;
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 4'd9;
    tick();
    chk("p1_c2a", ca(2), 0);
    chk("p1_c2b", cb(2), 0);
    chk("p1_c0", ca(0), 1);
    chk("p1_ovfb", 32'(ovf_b), 32'b010);
    clr = '0; ev = 3'b100;
    tick();
    chk("p2_c2", ca(2), 9);
    wr_sel = 2'd1; wr_data = 4'd3; ev = 3'b010;
    tick();
    chk("p3_c1", cb(1), 3);
    chk("p3_ovf", 32'(ovf_b), 0);
    chk("p3_any", 32'(any_a), 0);
    wr_sel = 2'd3; wr_data = 4'd7; ev = '0;
    tick();
    wr_en = 1'b0;
    chk("oor_wr", 32'(flat_a), 32'h931);

`ifndef EVENT_COUNTER_SNAPSHOT_EN
    // registered read port
    wr(0, 3); wr(1, 7); wr(2, 11);
    rd_sel = 2'd1;
    tick();
    chk("rd_c1", 32'(rd_a), 7);
    chk("rd_o1", 32'(rdo_a), 0);
    rd_sel = 2'd3;
    tick();
    chk("rd_oor", 32'(rd_b), 0);
    rd_sel = 2'd2; ev = 3'b100;
    tick();
    ev = '0;
    chk("rd_lat", 32'(rd_a), 11);
    chk("rd_live", ca(2), 12);
`else
    // snapshot excludes same-edge increments
    chk("sv_pre", 32'(sv_a), 0);
    wr(0, 4); wr(1, 4); wr(2, 4);
    snap = 1'b1; ev = 3'b111;
    tick();
    snap = 1'b0; ev = '0;
    chk("sn_live", 32'(flat_a), 32'h555);
    chk("sn_valid", 32'(sv_b), 1);
    rd_sel = 2'd0;
    tick();
    chk("sn_rd0", 32'(rd_a), 4);
    rd_sel = 2'd2;
    tick();
    chk("sn_rd2", 32'(rd_b), 4);
    rd_sel = 2'd3;
    tick();
    chk("sn_oor", 32'(rd_a), 0);
    chk("sn_hold", 32'(sv_a), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/event_counter_bank.md
# event_counter_bank

Parametrised bank of independent event counters that replaces the fixed three 20-bit counters for instruction-complete, memory-access and memory-correction events. Each channel counts a per-cycle strobe, either wrapping or saturating, and keeps a sticky overflow flag. Channels can be preloaded or cleared, and are read through a registered select port. The block sits beside the status register in the register file and feeds performance and debug readout.

## Interface
- CHANNELS, 3: number of counter channels (≥1).
- WIDTH, 20: counter width in bits (2..32).
- SATURATE, 0: 0 = wrap at max, 1 = hold at max.
- SEL_W, derived $clog2(CHANNELS) (min 1): select width. Not user-set.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- event  in  CHANNELS  per-channel strobe; adds one count per cycle while high.
- enable  in  CHANNELS  per-channel count gate; event ignored when low.
- clear  in  CHANNELS  per-channel synchronous clear of count and overflow.
- wr_en  in  1  preload strobe.
- wr_sel  in  SEL_W  channel to preload.
- wr_data  in  WIDTH  preload value.
- rd_sel  in  SEL_W  channel to read.
- rd_data  out  WIDTH  registered count of the selected channel.
- rd_overflow  out  1  registered overflow flag of the selected channel.
- count_flat  out  CHANNELS*WIDTH  live counts; channel i occupies bits [i*WIDTH +: WIDTH].
- overflow  out  CHANNELS  sticky per-channel overflow flags.
- any_overflow  out  1  OR of all overflow bits, combinational from registers.
- snap  in  1  snapshot request. Present only with the macro.
- snap_valid  out  1  snapshot holds data. Present only with the macro.

## Operation
- Each channel applies one action per edge, in priority order: clear[i] > (wr_en && wr_sel==i) > (event[i] && enable[i]) > hold.
- Clear: count ← 0, overflow ← 0.
- Write: count ← wr_data, overflow ← 0.
- Increment below max (2^WIDTH−1): count ← count+1.
- Increment at max, SATURATE=0: count ← 0, overflow ← 1.
- Increment at max, SATURATE=1: count unchanged, overflow ← 1.
- Overflow is sticky. Only clear, write or reset lower it.
- wr_sel ≥ CHANNELS: the write is ignored.
- rd_sel ≥ CHANNELS: rd_data and rd_overflow read as 0.
- Several channels may clear, write and increment in the same cycle with no interaction.

## Timing
- Reset values: all counts 0, overflow 0, any_overflow 0, rd_data 0, rd_overflow 0, snapshot store 0, snap_valid 0.
- Reset asserted mid-count aborts the count with no partial update. The first count edge is the first rising edge after reset deasserts.
- count_flat and overflow reflect an action one edge after it is sampled.
- Read latency is 1 cycle. rd_data at edge N+1 holds the count as it was before edge N's update, for the rd_sel sampled at edge N.

## Configuration
- EVENT_COUNTER_SNAPSHOT_EN defined:
  - Adds the snap and snap_valid ports and a CHANNELS×(WIDTH+1) shadow store.
  - snap high at an edge copies every pre-edge count and overflow flag atomically. Same-edge clear, write or increment is excluded from the copy.
  - snap_valid rises one edge after the first snap. Only reset clears it.
  - rd_data and rd_overflow read the shadow store instead of the live counters.
- Macro undefined: no shadow store, no snap or snap_valid ports. The read port reads the live counters.

## Structure
- Package event_counter_pkg holds:
  - function sel_width(n): returns $clog2, minimum 1.
  - localparam-style mode constants CNT_WRAP=0 and CNT_SAT=1.
  - typedef cnt_action_t {HOLD, CLEAR, WRITE, INC}.
- Sub-module event_counter_channel, one per channel via generate. Ports: clock, reset, clear, wr, wr_data, inc, count, overflow. Parameters: WIDTH, SATURATE.
- The top module holds the read mux, output registers and the optional shadow store.

## Test plan
- Reset during counting: CH0 at 5 with event held high; assert reset mid-cycle → count_flat, rd_data and overflow are 0 immediately, before any edge.
- Wrap: WIDTH=4, SATURATE=0; preload CH1 to 14, then event for 3 cycles → counts 15, 0, 1; overflow[1] is set at the 0 step and stays set.
- Saturate: WIDTH=4, SATURATE=1; preload to 14, then event for 3 cycles → counts 15, 15, 15; overflow set on the second edge; any_overflow=1.
- Priority: on one edge, CH2 gets clear=1, wr_en with wr_sel=2 and wr_data=9, and event=1 → count 0. Next edge, write without clear → count 9 and overflow cleared.
- Read port: counts {3,7,11}; rd_sel=1 → rd_data=7 one cycle later. rd_sel=3 (out of range) → rd_data=0.
- Snapshot (macro on): counts {4,4,4}; snap and event on all channels at the same edge → shadow reads 4 while live counts are 5; snap_valid=1 from the next cycle.
